// File: rtl/mux8_rr_arbiter_if.sv
// Bus between the eight-requester bank and the round-robin arbiter driving the shared 8:1 mux.
// Debug taps expose FSM state, fairness pointer and hold counter for checkers.
interface mux8_rr_arbiter_if #(
  parameter int CNT_W = 4
);
  // Handshake: requester k holds req[k] until it sees gnt[k] and has finished, then drops
  // req[k]. gnt/sel/busy are registered; y is only meaningful while busy=1.
  logic             en;
  logic [7:0]       req;
  logic [7:0]       din;
  logic [7:0]       gnt;
  logic [2:0]       sel;
  logic             busy;
  logic             y;
  logic             dbg_state;
  logic [2:0]       dbg_ptr;
  logic [CNT_W-1:0] dbg_hold_cnt;

  modport master (
    output en, req, din,
    input  gnt, sel, busy, y, dbg_state, dbg_ptr, dbg_hold_cnt
  );

  modport slave (
    input  en, req, din,
    output gnt, sel, busy, y, dbg_state, dbg_ptr, dbg_hold_cnt
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 single-bit mux path between eight requesters.
// Grants are registered; a release re-arbitrates in the same cycle so there is no idle bubble.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input logic              clk,
  input logic              rst,
  mux8_rr_arbiter_if.slave bus
);
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  localparam int               HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_LAST_I);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_e           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic [2:0] search_base;
  logic [2:0] pick;
  logic [2:0] idx;
  logic       found;
  logic       release_now;

  // While granted the base is sel+1, so the current holder is scanned last.
  always_comb begin
    search_base = (state_q == S_GRANT) ? sel_q + 3'd1 : ptr_q;
    found       = 1'b0;
    pick        = search_base;
    idx         = '0;
    for (int i = 0; i < 8; i++) begin
      idx = search_base + 3'(i);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    release_now = (state_q == S_GRANT) &&
                  (!bus.req[sel_q] || ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)));
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.en && found) begin
          state_d    = S_GRANT;
          gnt_d      = 8'd1 << pick;
          sel_d      = pick;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
        end
      end
      S_GRANT: begin
        if (release_now) begin
          ptr_d = sel_q + 3'd1;
          if (bus.en && found) begin
            gnt_d      = 8'd1 << pick;
            sel_d      = pick;
            hold_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
          end
        end else if (hold_cnt_q != CNT_MAX) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.sel          = sel_q;
  assign bus.busy         = busy_q;
  assign bus.y            = busy_q ? bus.din[sel_q] : 1'b0;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_ptr      = ptr_q;
  assign bus.dbg_hold_cnt = hold_cnt_q;
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: vector table plus rotation and forced-release sequences,
// with expected outputs queued at drive time and popped after each clock edge.
module tb_mux8_rr_arbiter;
  logic clk;
  logic rst;

  mux8_rr_arbiter_if #(.CNT_W(4)) bus8 ();
  mux8_rr_arbiter_if #(.CNT_W(4)) bus4 ();

  mux8_rr_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
  mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;
  } vec_t;

  vec_t        vecs[$];
  logic [12:0] exp_q[$];
  logic [16:0] exp4_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic vec_t mk(input string name, input logic r, input logic e,
                              input logic [7:0] rq, input logic [7:0] d,
                              input logic [7:0] g, input logic [2:0] s,
                              input logic b, input logic yy);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.req = rq; v.din = d;
    v.gnt = g; v.sel = s; v.busy = b; v.y = yy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Drive dut8 for one cycle; expected {gnt,sel,busy,y} is queued then compared after the edge.
  task automatic drive8(input string name, input logic r, input logic e, input logic [7:0] rq,
                        input logic [7:0] d, input logic [12:0] exp);
    logic [12:0] want;
    @(negedge clk);
    rst = r; bus8.en = e; bus8.req = rq; bus8.din = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      want = exp_q.pop_front();
      check(name, {19'd0, bus8.gnt, bus8.sel, bus8.busy, bus8.y}, {19'd0, want});
    end
  endtask

  // dut4 variant also checks the hold counter.
  task automatic drive4(input string name, input logic [7:0] rq, input logic [7:0] d,
                        input logic [16:0] exp);
    logic [16:0] want;
    @(negedge clk);
    rst = 1'b0; bus4.en = 1'b1; bus4.req = rq; bus4.din = d;
    exp4_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp4_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      want = exp4_q.pop_front();
      check(name, {15'd0, bus4.gnt, bus4.sel, bus4.busy, bus4.y, bus4.dbg_hold_cnt},
            {15'd0, want});
    end
  endtask

  initial begin
    rst = 1'b1;
    bus8.en = 1'b0; bus8.req = '0; bus8.din = '0;
    bus4.en = 1'b0; bus4.req = '0; bus4.din = '0;

    vecs.push_back(mk("reset",           1, 0, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0));
    vecs.push_back(mk("t1_grant0",       0, 1, 8'h01, 8'h01, 8'h01, 3'd0, 1, 1));
    vecs.push_back(mk("t1_release",      0, 1, 8'h00, 8'h01, 8'h00, 3'd0, 0, 0));
    vecs.push_back(mk("ptr_grant5",      0, 1, 8'h20, 8'h20, 8'h20, 3'd5, 1, 1));
    vecs.push_back(mk("ptr_release5",    0, 1, 8'h00, 8'h20, 8'h00, 3'd5, 0, 0));
    vecs.push_back(mk("t3_grant6",       0, 1, 8'h41, 8'h40, 8'h40, 3'd6, 1, 1));
    vecs.push_back(mk("t3_wrap0",        0, 1, 8'h01, 8'h40, 8'h01, 3'd0, 1, 0));
    vecs.push_back(mk("t3_idle",         0, 1, 8'h00, 8'h00, 8'h00, 3'd0, 0, 0));
    vecs.push_back(mk("t4_grant3",       0, 1, 8'h08, 8'h18, 8'h08, 3'd3, 1, 1));
    vecs.push_back(mk("t4_hold_en0_a",   0, 0, 8'hF8, 8'h18, 8'h08, 3'd3, 1, 1));
    vecs.push_back(mk("t4_hold_en0_b",   0, 0, 8'hF8, 8'h18, 8'h08, 3'd3, 1, 1));
    vecs.push_back(mk("t4_release_idle", 0, 0, 8'hF0, 8'h18, 8'h00, 3'd3, 0, 0));
    vecs.push_back(mk("t4_blocked_a",    0, 0, 8'hF0, 8'h18, 8'h00, 3'd3, 0, 0));
    vecs.push_back(mk("t4_blocked_b",    0, 0, 8'hF0, 8'h18, 8'h00, 3'd3, 0, 0));
    vecs.push_back(mk("t6_grant4",       0, 1, 8'hF0, 8'h18, 8'h10, 3'd4, 1, 1));
    vecs.push_back(mk("t6_hold4",        0, 1, 8'h30, 8'h18, 8'h10, 3'd4, 1, 1));
    vecs.push_back(mk("t6_rst",          1, 1, 8'h30, 8'h18, 8'h00, 3'd0, 0, 0));
    vecs.push_back(mk("t6_after_rst",    0, 1, 8'h30, 8'h18, 8'h10, 3'd4, 1, 1));
    vecs.push_back(mk("t6_drop",         0, 1, 8'h00, 8'h18, 8'h00, 3'd4, 0, 0));

    foreach (vecs[i])
      drive8(vecs[i].name, vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].din,
             {vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].y});

    // Full-load rotation: each index owns the bus for exactly MAX_HOLD=8 cycles, back to back.
    drive8("t2_reset", 1, 0, 8'h00, 8'h00, 13'd0);
    for (int c = 0; c < 72; c++) begin
      logic [7:0] d;
      logic [2:0] k;
      d = 8'($urandom_range(0, 255));
      k = 3'((c / 8) % 8);
      drive8($sformatf("t2_rot_c%0d", c), 0, 1, 8'hFF, d,
             {8'd1 << k, k, 1'b1, d[k]});
    end

    // Sole requester with MAX_HOLD=4: forced release re-grants it with no gap.
    drive8("t5_reset", 1, 0, 8'h00, 8'h00, 13'd0);
    for (int c = 0; c < 12; c++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      drive4($sformatf("t5_hold_c%0d", c), 8'h20, d,
             {8'h20, 3'd5, 1'b1, d[5], 4'(c % 4)});
    end

    if (exp_q.size() != 0 || exp4_q.size() != 0)
      check("scoreboard_drained", 32'(exp_q.size() + exp4_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
